alu_muldiv_unit: RTL and testbench

//  Parametrised EX-stage ALU with integrated ALUOp/func decode and an iterative HI/LO multiply/divide engine.

---
 rtl/alu_pkg.sv | 104 ++++++++++
 rtl/muldiv_core.sv | 116 +++++++++++
 rtl/alu_muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_alu_muldiv_unit.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, internal op encoding, engine states and the
// ALUOp/func decoder shared by alu_muldiv_unit and muldiv_core.
package alu_pkg;

  localparam logic [2:0] ALUOP_ADD  = 3'b000;
  localparam logic [2:0] ALUOP_SUB  = 3'b001;
  localparam logic [2:0] ALUOP_AND  = 3'b010;
  localparam logic [2:0] ALUOP_OR   = 3'b011;
  localparam logic [2:0] ALUOP_XOR  = 3'b100;
  localparam logic [2:0] ALUOP_SLT  = 3'b101;
  localparam logic [2:0] ALUOP_SLTU = 3'b110;
  localparam logic [2:0] ALUOP_FUNC = 3'b111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [3:0] {
    OP_NONE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MT, OP_MD
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Decoded operation: the 4-bit op plus modifiers that do not need their own op code
  typedef struct packed {
    alu_op_e op;
    logic    var_sh;     // shift amount taken from a instead of shamt
    logic    ovf_chk;    // add/sub that reports signed overflow
    logic    md_div;     // divide (vs multiply)
    logic    md_signed;  // signed multiply/divide
    logic    to_hi;      // mthi (vs mtlo)
  } dec_t;

  function automatic dec_t decode_op(input logic [2:0] alu_op, input logic [5:0] func);
    dec_t d;
    d = '0;
    case (alu_op)
      ALUOP_ADD:  begin d.op = OP_ADD; d.ovf_chk = 1'b1; end
      ALUOP_SUB:  begin d.op = OP_SUB; d.ovf_chk = 1'b1; end
      ALUOP_AND:  d.op = OP_AND;
      ALUOP_OR:   d.op = OP_OR;
      ALUOP_XOR:  d.op = OP_XOR;
      ALUOP_SLT:  d.op = OP_SLT;
      ALUOP_SLTU: d.op = OP_SLTU;
      default: begin
        case (func)
          FN_SLL:   d.op = OP_SLL;
          FN_SRL:   d.op = OP_SRL;
          FN_SRA:   d.op = OP_SRA;
          FN_SLLV:  begin d.op = OP_SLL; d.var_sh = 1'b1; end
          FN_SRLV:  begin d.op = OP_SRL; d.var_sh = 1'b1; end
          FN_SRAV:  begin d.op = OP_SRA; d.var_sh = 1'b1; end
          FN_MFHI:  d.op = OP_MFHI;
          FN_MFLO:  d.op = OP_MFLO;
          FN_MTHI:  begin d.op = OP_MT; d.to_hi = 1'b1; end
          FN_MTLO:  d.op = OP_MT;
          FN_MULT:  begin d.op = OP_MD; d.md_signed = 1'b1; end
          FN_MULTU: d.op = OP_MD;
          FN_DIV:   begin d.op = OP_MD; d.md_div = 1'b1; d.md_signed = 1'b1; end
          FN_DIVU:  begin d.op = OP_MD; d.md_div = 1'b1; end
          FN_ADD:   begin d.op = OP_ADD; d.ovf_chk = 1'b1; end
          FN_ADDU:  d.op = OP_ADD;
          FN_SUB:   begin d.op = OP_SUB; d.ovf_chk = 1'b1; end
          FN_SUBU:  d.op = OP_SUB;
          FN_AND:   d.op = OP_AND;
          FN_OR:    d.op = OP_OR;
          FN_XOR:   d.op = OP_XOR;
          FN_NOR:   d.op = OP_NOR;
          FN_SLT:   d.op = OP_SLT;
          FN_SLTU:  d.op = OP_SLTU;
          default:  d.op = OP_NONE;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: iterative magnitude multiply (shift-add) / divide (restoring)
// with sign fixup. Results are presented combinationally while in MD_FIX.
module muldiv_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin_c,
  output logic [WIDTH-1:0] hi_c,
  output logic [WIDTH-1:0] lo_c,
  output logic             dbz_c
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned PW  = 2 * WIDTH;

  md_state_e        state;
  logic [SHW-1:0]   cnt;
  logic [PW-1:0]    acc;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] dvs;     // multiplicand or divisor magnitude
  logic             div_q;
  logic             neg_lo;  // negate quotient, or the whole product for mult
  logic             neg_hi;  // negate remainder
  logic             dbz_q;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   add_sum, rem_sh, rem_diff;
  logic [PW-1:0]    prod_fix;

  // Operand magnitudes and one iteration step of each algorithm
  always_comb begin
    mag_a    = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b    = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    add_sum  = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, dvs} : '0);
    rem_sh   = acc[PW-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, dvs};
  end

  // Sign fixup of the finished magnitudes
  always_comb begin
    prod_fix = neg_lo ? (~acc + PW'(1)) : acc;
    if (div_q) begin
      lo_c = neg_lo ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      hi_c = neg_hi ? (~acc[PW-1:WIDTH] + WIDTH'(1)) : acc[PW-1:WIDTH];
    end else begin
      lo_c = prod_fix[WIDTH-1:0];
      hi_c = prod_fix[PW-1:WIDTH];
    end
    fin_c = (state == MD_FIX);
    dbz_c = fin_c && dbz_q;
  end

  // Engine FSM: IDLE latches operands, RUN iterates WIDTH times, FIX hands off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      div_q  <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            div_q <= is_div;
            cnt   <= '0;
            dbz_q <= 1'b0;
            if (is_div && (b == '0)) begin
              // Divide by zero bypasses RUN: hi gets the raw dividend, lo all ones
              acc    <= {a, {WIDTH{1'b1}}};
              neg_lo <= 1'b0;
              neg_hi <= 1'b0;
              dbz_q  <= 1'b1;
              state  <= MD_FIX;
            end else if (is_div) begin
              acc    <= {{WIDTH{1'b0}}, mag_a};
              dvs    <= mag_b;
              neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= is_signed && a[WIDTH-1];
              state  <= MD_RUN;
            end else begin
              acc    <= {{WIDTH{1'b0}}, mag_b};
              dvs    <= mag_a;
              neg_lo <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_hi <= 1'b0;
              state  <= MD_RUN;
            end
          end
        end
        MD_RUN: begin
          if (div_q) begin
            if (!rem_diff[WIDTH]) acc <= {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + SHW'(1);
          if (cnt == SHW'(WIDTH - 1)) state <= MD_FIX;
        end
        MD_FIX:  state <= MD_IDLE;
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: EX-stage ALU with ALUOp/func decode, single-cycle datapath,
// HI/LO registers and an iterative multiply/divide engine (muldiv_core).
// Optional feature macro: ALU_OVF_EN adds the registered signed-overflow port ovf.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       func,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  dec_t             dec;
  logic             accept;
  logic             md_start;
  logic [SHW-1:0]   sh_amt;
  logic [WIDTH-1:0] sum, dif, res_c;
  logic             fin_c, dbz_c;
  logic [WIDTH-1:0] md_hi_c, md_lo_c;

  // Decode and issue qualification; start is ignored while the engine is busy
  always_comb begin
    dec      = decode_op(ALUOp, func);
    accept   = start && !busy;
    md_start = accept && (dec.op == OP_MD);
  end

  // Single-cycle datapath; mthi/mtlo and unknown funcs produce result 0
  always_comb begin
    sh_amt = dec.var_sh ? a[SHW-1:0] : shamt;
    sum    = a + b;
    dif    = a - b;
    case (dec.op)
      OP_ADD:  res_c = sum;
      OP_SUB:  res_c = dif;
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_NOR:  res_c = ~(a | b);
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  res_c = b << sh_amt;
      OP_SRL:  res_c = b >> sh_amt;
      OP_SRA:  res_c = $unsigned($signed(b) >>> sh_amt);
      OP_MFHI: res_c = hi;
      OP_MFLO: res_c = lo;
      default: res_c = '0;
    endcase
  end

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_muldiv_core (
    .clk       (clk),
    .rst       (rst),
    .start     (md_start),
    .is_div    (dec.md_div),
    .is_signed (dec.md_signed),
    .a         (a),
    .b         (b),
    .fin_c     (fin_c),
    .hi_c      (md_hi_c),
    .lo_c      (md_lo_c),
    .dbz_c     (dbz_c)
  );

  // Output registers: single-cycle results at issue, HI/LO at engine completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result      <= '0;
      zero        <= 1'b1;
      done        <= 1'b0;
      busy        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fin_c) begin
        hi          <= md_hi_c;
        lo          <= md_lo_c;
        div_by_zero <= dbz_c;
        done        <= 1'b1;
        busy        <= 1'b0;
      end else if (accept) begin
        div_by_zero <= 1'b0;
        if (dec.op == OP_MD) begin
          busy <= 1'b1;
        end else begin
          result <= res_c;
          zero   <= (res_c == '0);
          done   <= 1'b1;
          if (dec.op == OP_MT) begin
            if (dec.to_hi) hi <= a;
            else           lo <= a;
          end
        end
      end
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_c;

  // Signed overflow of the checked add/sub forms
  always_comb begin
    ovf_c = 1'b0;
    if (dec.ovf_chk) begin
      if (dec.op == OP_ADD)
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      else if (dec.op == OP_SUB)
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // Overflow flag follows done; multiply/divide completions clear it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              ovf <= 1'b0;
    else if (fin_c)                       ovf <= 1'b0;
    else if (accept && dec.op != OP_MD)   ovf <= ovf_c;
  end
`else
  logic unused_ovf_chk;
  assign unused_ovf_chk = dec.ovf_chk;
`endif

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: scoreboard bench for alu_muldiv_unit (WIDTH=32).
// Expected responses come from an arithmetic reference model and are queued
// at issue; a negedge monitor pops and compares on every done pulse.
module tb_alu_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned SHW = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2:0]     ALUOp;
  logic [5:0]     func;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   a, b;
  logic [W-1:0]   result, hi, lo;
  logic           zero, done, busy, div_by_zero;
`ifdef ALU_OVF_EN
  logic           ovf;
`endif

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ALUOp       (ALUOp),
    .func        (func),
    .shamt       (shamt),
    .a           (a),
    .b           (b),
    .result      (result),
    .zero        (zero),
    .done        (done),
    .busy        (busy),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
`ifdef ALU_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] mhi = '0, mlo = '0, mres = '0;

  localparam logic [5:0] F_SRA = 6'b000011, F_MFHI = 6'b010000, F_MFLO = 6'b010010;
  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV = 6'b011010, F_DIVU = 6'b011011;
  localparam logic [5:0] F_ADD = 6'b100000, F_ADDU = 6'b100001;

  logic [5:0] fn_tab [24] = '{
    6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
    6'b010000, 6'b010001, 6'b010010, 6'b010011, 6'b011000, 6'b011001,
    6'b011010, 6'b011011, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
    6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: MIPS semantics with plain 64-bit arithmetic
  task automatic model(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] av, input logic [31:0] bv,
                       output exp_t e, output bit md);
    longint      sa, sb, s, q, rm;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    r = '0; md = 1'b0; e.dbz = 1'b0; e.ovf = 1'b0;
    if (op != 3'd7) begin
      case (op)
        3'd0: begin s = sa + sb; r = s[31:0];
                e.ovf = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000)); end
        3'd1: begin s = sa - sb; r = s[31:0];
                e.ovf = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000)); end
        3'd2: r = av & bv;
        3'd3: r = av | bv;
        3'd4: r = av ^ bv;
        3'd5: r = {31'b0, sa < sb};
        default: r = {31'b0, av < bv};
      endcase
    end else begin
      case (fn)
        6'b000000: r = bv << sh;
        6'b000010: r = bv >> sh;
        6'b000011: r = $signed(bv) >>> sh;
        6'b000100: r = bv << av[4:0];
        6'b000110: r = bv >> av[4:0];
        6'b000111: r = $signed(bv) >>> av[4:0];
        6'b010000: r = mhi;
        6'b010010: r = mlo;
        6'b010001: mhi = av;
        6'b010011: mlo = av;
        6'b100000, 6'b100010: begin
          s = (fn == 6'b100000) ? sa + sb : sa - sb;
          r = s[31:0];
          e.ovf = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000));
        end
        6'b100001: r = av + bv;
        6'b100011: r = av - bv;
        6'b100100: r = av & bv;
        6'b100101: r = av | bv;
        6'b100110: r = av ^ bv;
        6'b100111: r = ~(av | bv);
        6'b101010: r = {31'b0, sa < sb};
        6'b101011: r = {31'b0, av < bv};
        6'b011000: begin md = 1'b1; p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
        6'b011001: begin md = 1'b1; p = {32'b0, av} * {32'b0, bv}; mhi = p[63:32]; mlo = p[31:0]; end
        6'b011010, 6'b011011: begin
          md = 1'b1;
          if (bv == '0) begin
            mhi = av; mlo = '1; e.dbz = 1'b1;
          end else if (fn == 6'b011010) begin
            q = sa / sb; rm = sa % sb; mlo = q[31:0]; mhi = rm[31:0];
          end else begin
            p = {32'b0, av} / {32'b0, bv}; mlo = p[31:0];
            p = {32'b0, av} % {32'b0, bv}; mhi = p[31:0];
          end
        end
        default: r = '0;
      endcase
    end
    if (md) r = mres;
    else    mres = r;
    e.res = r; e.hi = mhi; e.lo = mlo;
  endtask

  // Wait for the outstanding multi-cycle op, optionally pulsing start mid-op
  task automatic wait_md(input bit junk);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      if (junk && n == 3) begin
        ALUOp = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk); start = 1'b0;
      end else begin
        @(negedge clk);
      end
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL md_timeout: %0d responses outstanding after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  // Issue one op at the current negedge; multi-cycle ops are waited out
  task automatic run_op(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] av, input logic [31:0] bv, input bit junk);
    exp_t e;
    bit   md;
    model(op, fn, sh, av, bv, e, md);
    e.due = cyc + 1 + (md ? (e.dbz ? 1 : W + 1) : 0);
    exp_q.push_back(e);
    ALUOp = op; func = fn; shamt = sh; a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (md) begin
      chk("busy_inflight", 32'(busy), 32'd1);
      wait_md(junk);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_result"}, result, 32'd0);
    chk({pfx, "_zero"}, 32'(zero), 32'd1);
    chk({pfx, "_done"}, 32'(done), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_hi"}, hi, 32'd0);
    chk({pfx, "_lo"}, lo, 32'd0);
    chk({pfx, "_dbz"}, 32'(div_by_zero), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_done: result %h with nothing outstanding (cycle %0d)", result, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("result", result, e.res);
        chk("zero", 32'(zero), 32'(e.res == 32'd0));
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("busy_at_done", 32'(busy), 32'd0);
`ifdef ALU_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; ALUOp = '0; func = '0; shamt = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases
    run_op(3'd0, 6'd0, 5'd0, 32'd7, 32'd5, 1'b0);
    run_op(3'd7, F_MULT,  5'd0, 32'hFFFF_FFFD, 32'd4, 1'b0);
    run_op(3'd7, F_MULTU, 5'd0, 32'hFFFF_FFFD, 32'd4, 1'b1);
    run_op(3'd7, F_DIV,   5'd0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd7, F_DIVU,  5'd0, 32'd7, 32'd0, 1'b0);
    run_op(3'd7, F_MFHI,  5'd0, 32'd0, 32'd0, 1'b0);
    run_op(3'd7, F_MFLO,  5'd0, 32'd0, 32'd0, 1'b0);
    run_op(3'd7, F_SRA,   5'd4, 32'd0, 32'h8000_0000, 1'b0);
    run_op(3'd5, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(3'd6, 6'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(3'd1, 6'd0, 5'd0, 32'h1234_5678, 32'h1234_5678, 1'b0);
    run_op(3'd7, F_DIV,   5'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(3'd7, F_ADD,   5'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(3'd7, F_ADDU,  5'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
    run_op(3'd7, 6'b000001, 5'd3, 32'd9, 32'd9, 1'b0);

    // Reset in the middle of a multiply aborts it
    begin
      exp_t e;
      bit   md;
      model(3'd7, F_MULT, 5'd0, 32'h0001_2345, 32'h0000_0777, e, md);
      ALUOp = 3'd7; func = F_MULT; a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
      @(negedge clk);
      ALUOp = 3'd0; a = 32'd1; b = 32'd2;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      exp_q.delete();
      mhi = '0; mlo = '0; mres = '0;
      check_reset("midop_rst");
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd0, 6'd0, 5'd0, 32'd100, 32'd23, 1'b0);
      run_op(3'd7, F_MFHI, 5'd0, 32'd0, 32'd0, 1'b0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [2:0]  op;
      logic [5:0]  fn;
      logic [31:0] av, bv;
      op = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom);
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 23)];
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 6))
        0: bv = '0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: bv = av;
        3: begin av = 32'($urandom_range(0, 20)); bv = 32'($urandom_range(0, 20)); end
        default: ;
      endcase
      run_op(op, fn, 5'($urandom), av, bv, 1'($urandom));
    end

    repeat (3) @(negedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
